// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register decode,
// byte offsets for software and benches, and ID word layout.
package irq_ctrl_pkg;

  // Widest source vector the controller supports.
  localparam int unsigned MAX_SRC = 16;

  // Register index as decoded from addr[4:2].
  typedef enum logic [2:0] {
    REG_STATUS = 3'd0,
    REG_RAW    = 3'd1,
    REG_ENABLE = 3'd2,
    REG_FIQSEL = 3'd3,
    REG_CLEAR  = 3'd4,
    REG_SET    = 3'd5,
    REG_IRQ_ID = 3'd6,
    REG_FIQ_ID = 3'd7
  } reg_sel_e;

  // Byte offsets of each register within the controller window.
  localparam logic [31:0] OFS_STATUS = 32'h0000_0000;
  localparam logic [31:0] OFS_RAW    = 32'h0000_0004;
  localparam logic [31:0] OFS_ENABLE = 32'h0000_0008;
  localparam logic [31:0] OFS_FIQSEL = 32'h0000_000C;
  localparam logic [31:0] OFS_CLEAR  = 32'h0000_0010;
  localparam logic [31:0] OFS_SET    = 32'h0000_0014;
  localparam logic [31:0] OFS_IRQ_ID = 32'h0000_0018;
  localparam logic [31:0] OFS_FIQ_ID = 32'h0000_001C;

  // ID word layout: a valid flag at the top and the source index at the bottom.
  localparam int unsigned ID_VALID_BIT = 31;
  localparam int unsigned ID_IDX_LSB   = 0;
  localparam int unsigned ID_IDX_W     = 4;

  // Build an ID word naming the lowest set bit of vec; all zero if none set.
  function automatic logic [31:0] lowest_id(input logic [MAX_SRC-1:0] vec);
    logic [31:0] id;
    id = 32'h0000_0000;
    // Scan downwards so the lowest active index is the last one written.
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        id = 32'h0000_0000;
        id[ID_VALID_BIT] = 1'b1;
        id[ID_IDX_LSB +: ID_IDX_W] = i[ID_IDX_W-1:0];
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Per-source two-flop synchronizer followed by a rising-edge detector.
// Sources are asynchronous to clk; only the synchronized copies are used.
module irq_sync_edge #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] i_src,
  output logic [NSRC-1:0] o_rise
);

  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;
  logic [NSRC-1:0] r_sync3;

  // Metastability chain plus one extra stage that remembers the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= {NSRC{1'b0}};
      r_sync2 <= {NSRC{1'b0}};
      r_sync3 <= {NSRC{1'b0}};
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // A source held high across reset release shows up as a fresh edge,
  // because all three stages start from zero.
  assign o_rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges of NSRC sources into pending
// bits, masks and routes them to a normal (irq) or fast (firq) request, and
// exposes everything through a small word-addressed register window.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [31:0]     write_data,
  output logic [31:0]     read_data,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic            firq
);

  // Architectural state.
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_enable;
  logic [NSRC-1:0] r_fiqsel;
  logic            r_irq;
  logic            r_firq;

  // Bus decode and next-state helpers.
  reg_sel_e        w_reg;
  logic            w_wr;
  logic            w_wr_enable;
  logic            w_wr_fiqsel;
  logic [NSRC-1:0] w_clr_mask;
  logic [NSRC-1:0] w_set_mask;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_pending_nxt;

  // Request candidates and their ID words.
  logic [NSRC-1:0]    w_irq_cand;
  logic [NSRC-1:0]    w_fiq_cand;
  logic [MAX_SRC-1:0] w_irq_cand_ext;
  logic [MAX_SRC-1:0] w_fiq_cand_ext;
  logic [31:0]        w_irq_id;
  logic [31:0]        w_fiq_id;

  // Address bits outside addr[4:2] and data bits above the field are ignored.
  logic w_unused;
  assign w_unused = ^{addr[31:5], addr[1:0], write_data[31:NSRC]};

  irq_sync_edge #(
    .NSRC (NSRC)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .i_src  (src),
    .o_rise (w_rise)
  );

  assign w_reg = reg_sel_e'(addr[4:2]);
  assign w_wr  = sel & we;

  // Decode a bus write into register strobes and pending set/clear masks.
  always_comb begin
    w_wr_enable = 1'b0;
    w_wr_fiqsel = 1'b0;
    w_clr_mask  = {NSRC{1'b0}};
    w_set_mask  = {NSRC{1'b0}};
    if (w_wr) begin
      case (w_reg)
        REG_ENABLE: w_wr_enable = 1'b1;
        REG_FIQSEL: w_wr_fiqsel = 1'b1;
        REG_CLEAR:  w_clr_mask  = write_data[NSRC-1:0];
        REG_SET:    w_set_mask  = write_data[NSRC-1:0];
        default: begin
          // Read-only registers ignore writes.
          w_wr_enable = 1'b0;
          w_wr_fiqsel = 1'b0;
        end
      endcase
    end else begin
      w_wr_enable = 1'b0;
      w_wr_fiqsel = 1'b0;
    end
  end

  // Clear is applied first so a coincident edge or SET always wins.
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask | w_rise;

  // Pending, enable and route registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= {NSRC{1'b0}};
      r_enable  <= {NSRC{1'b0}};
      r_fiqsel  <= {NSRC{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
      if (w_wr_enable) begin
        r_enable <= write_data[NSRC-1:0];
      end
      if (w_wr_fiqsel) begin
        r_fiqsel <= write_data[NSRC-1:0];
      end
    end
  end

  assign w_irq_cand = r_pending & r_enable & ~r_fiqsel;
  assign w_fiq_cand = r_pending & r_enable &  r_fiqsel;

  // Registered requests: one cycle after pending/enable/route change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq  <= 1'b0;
      r_firq <= 1'b0;
    end else begin
      r_irq  <= |w_irq_cand;
      r_firq <= |w_fiq_cand;
    end
  end

  assign irq  = r_irq;
  assign firq = r_firq;

  // Widen candidate vectors to the fixed width the ID helper expects.
  always_comb begin
    w_irq_cand_ext = {MAX_SRC{1'b0}};
    w_fiq_cand_ext = {MAX_SRC{1'b0}};
    w_irq_cand_ext[NSRC-1:0] = w_irq_cand;
    w_fiq_cand_ext[NSRC-1:0] = w_fiq_cand;
  end

  assign w_irq_id = lowest_id(w_irq_cand_ext);
  assign w_fiq_id = lowest_id(w_fiq_cand_ext);

  // Combinational read mux; reads see register state before any same-cycle write.
  always_comb begin
    read_data = 32'h0000_0000;
    if (sel) begin
      case (w_reg)
        REG_STATUS: read_data[NSRC-1:0] = r_pending & r_enable;
        REG_RAW:    read_data[NSRC-1:0] = r_pending;
        REG_ENABLE: read_data[NSRC-1:0] = r_enable;
        REG_FIQSEL: read_data[NSRC-1:0] = r_fiqsel;
        REG_IRQ_ID: read_data = w_irq_id;
        REG_FIQ_ID: read_data = w_fiq_id;
        default:    read_data = 32'h0000_0000;
      endcase
    end else begin
      read_data = 32'h0000_0000;
    end
  end

endmodule
